// File: rtl/mcpu_core_pkg.sv
// rtl/mcpu_core_pkg.sv - shared core constants and the fetch-queue entry type
package mcpu_core_pkg;

  localparam int INST_W        = 32;
  localparam int FETCH_Q_DEPTH = 4;
  localparam int FQ_PC_W       = 30;

  // One queued fetch slot: word-address PC tag plus the raw instruction word
  typedef struct packed {
    logic [FQ_PC_W-1:0] pc;
    logic [INST_W-1:0]  inst;
  } fq_entry_t;

endpackage

// File: rtl/mcpu_core_fetch_queue_mem.sv
// rtl/mcpu_core_fetch_queue_mem.sv - fetch-queue entry storage, one write port and two read ports
module mcpu_core_fetch_queue_mem
  import mcpu_core_pkg::*;
#(
  parameter int  DEPTH   = FETCH_Q_DEPTH,
  parameter type entry_t = fq_entry_t
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  entry_t                   i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr_head,
  output entry_t                   o_rdata_head,
  input  logic [$clog2(DEPTH)-1:0] i_raddr_next,
  output entry_t                   o_rdata_next
);

  // Contents are deliberately not reset; the top masks reads with its valid bits
  entry_t r_mem [DEPTH];

  // Single write port, driven by an accepted push
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_head = r_mem[i_raddr_head];
  assign o_rdata_next = r_mem[i_raddr_next];

endmodule

// File: rtl/mcpu_core_fetch_queue.sv
// rtl/mcpu_core_fetch_queue.sv - fetch-to-decode instruction queue; optional stats via MCPU_FETCH_QUEUE_STATS_EN
module mcpu_core_fetch_queue
  import mcpu_core_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int PC_W  = 30
) (
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst_n,
  input  logic              f2q_valid,
  input  logic [INST_W-1:0] f2q_inst,
  input  logic [PC_W-1:0]   f2q_pc,
  output logic              q2f_ready,
  output logic [INST_W-1:0] q2d_inst,
  output logic [PC_W-1:0]   q2d_pc,
  output logic              q2d_inst_valid,
  output logic [INST_W-1:0] q2d_nextinst,
  output logic              q2d_next_valid,
  output logic              q2d_prev_long_imm,
  input  logic              d2q_advance,
  input  logic              d2q_long_imm,
  input  logic              flush
`ifdef MCPU_FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]       q2s_bubble_cnt,
  output logic [31:0]       q2s_full_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  // Entry layout follows the configured PC width rather than the package default
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_prev_long_imm;

  logic          w_ready;
  logic          w_inst_valid;
  logic          w_next_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_we;
  logic [AW-1:0] w_rd_next;
  entry_t        w_wdata;
  entry_t        w_head;
  entry_t        w_second;

  // Handshake terms come only from registered state, so ready never sees advance
  assign w_ready      = (r_count < FULL_CNT);
  assign w_inst_valid = (r_count != '0);
  assign w_next_valid = (r_count > CNT_ONE);
  assign w_push       = f2q_valid & w_ready;
  assign w_pop        = d2q_advance & w_inst_valid;
  assign w_we         = w_push & ~flush;
  assign w_rd_next    = r_rd_ptr + PTR_ONE;
  assign w_wdata      = '{pc: f2q_pc, inst: f2q_inst};

  mcpu_core_fetch_queue_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .i_clk        (clkrst_core_clk),
    .i_we         (w_we),
    .i_waddr      (r_wr_ptr),
    .i_wdata      (w_wdata),
    .i_raddr_head (r_rd_ptr),
    .o_rdata_head (w_head),
    .i_raddr_next (w_rd_next),
    .o_rdata_next (w_second)
  );

  // Pointer, occupancy and payload-marker update; reset and flush both empty the queue
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n || flush) begin
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_prev_long_imm <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr        <= w_rd_next;
        // a payload word cannot itself announce a following payload
        r_prev_long_imm <= d2q_long_imm & ~r_prev_long_imm;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign q2f_ready         = w_ready;
  assign q2d_inst_valid    = w_inst_valid;
  assign q2d_next_valid    = w_next_valid;
  assign q2d_prev_long_imm = r_prev_long_imm;
  assign q2d_inst          = w_inst_valid ? w_head.inst   : '0;
  assign q2d_pc            = w_inst_valid ? w_head.pc     : '0;
  assign q2d_nextinst      = w_next_valid ? w_second.inst : '0;

  // Protocol checks on decode: no advance from an empty queue, no long-imm advance without its payload
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst_n && !flush) begin
      assert (!(d2q_advance && !w_inst_valid));
      assert (!(d2q_advance && d2q_long_imm && !r_prev_long_imm && !w_next_valid));
    end
  end

`ifdef MCPU_FETCH_QUEUE_STATS_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_full_cnt;

  // Saturating occupancy statistics; only reset clears them, flush does not
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      r_bubble_cnt <= '0;
      r_full_cnt   <= '0;
    end else begin
      if (!w_inst_valid && !flush && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if ((r_count == FULL_CNT) && (r_full_cnt != 32'hFFFF_FFFF)) begin
        r_full_cnt <= r_full_cnt + 32'd1;
      end
    end
  end

  assign q2s_bubble_cnt = r_bubble_cnt;
  assign q2s_full_cnt   = r_full_cnt;
`endif

endmodule

// File: tb/tb_mcpu_core_fetch_queue.sv
// tb/tb_mcpu_core_fetch_queue.sv - self-checking bench for the fetch queue against a queue-based reference
module tb_mcpu_core_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 30;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            f2q_valid;
  logic [31:0]     f2q_inst;
  logic [PC_W-1:0] f2q_pc;
  logic            q2f_ready;
  logic [31:0]     q2d_inst;
  logic [PC_W-1:0] q2d_pc;
  logic            q2d_inst_valid;
  logic [31:0]     q2d_nextinst;
  logic            q2d_next_valid;
  logic            q2d_prev_long_imm;
  logic            d2q_advance;
  logic            d2q_long_imm;
  logic            flush;
`ifdef MCPU_FETCH_QUEUE_STATS_EN
  logic [31:0]     q2s_bubble_cnt;
  logic [31:0]     q2s_full_cnt;
`endif

  always #5 clk = ~clk;

  mcpu_core_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .f2q_valid         (f2q_valid),
    .f2q_inst          (f2q_inst),
    .f2q_pc            (f2q_pc),
    .q2f_ready         (q2f_ready),
    .q2d_inst          (q2d_inst),
    .q2d_pc            (q2d_pc),
    .q2d_inst_valid    (q2d_inst_valid),
    .q2d_nextinst      (q2d_nextinst),
    .q2d_next_valid    (q2d_next_valid),
    .q2d_prev_long_imm (q2d_prev_long_imm),
    .d2q_advance       (d2q_advance),
    .d2q_long_imm      (d2q_long_imm),
    .flush             (flush)
`ifdef MCPU_FETCH_QUEUE_STATS_EN
    ,
    .q2s_bubble_cnt    (q2s_bubble_cnt),
    .q2s_full_cnt      (q2s_full_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference: FIFO of {pc, inst}, the payload marker, and the statistics
  logic [PC_W+31:0] mq[$];
  bit               mprev;
  longint           mbub;
  longint           mfull;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int sz;
    logic [31:0]     e_inst;
    logic [31:0]     e_next;
    logic [PC_W-1:0] e_pc;
    sz = mq.size();
    e_inst = '0;
    e_next = '0;
    e_pc   = '0;
    if (sz > 0) begin
      e_inst = mq[0][31:0];
      e_pc   = mq[0][PC_W+31:32];
    end
    if (sz > 1) e_next = mq[1][31:0];
    chk("ready",      q2f_ready,         sz < DEPTH);
    chk("inst_valid", q2d_inst_valid,    sz > 0);
    chk("next_valid", q2d_next_valid,    sz > 1);
    chk("inst",       q2d_inst,          e_inst);
    chk("pc",         q2d_pc,            e_pc);
    chk("nextinst",   q2d_nextinst,      e_next);
    chk("prev_limm",  q2d_prev_long_imm, mprev);
`ifdef MCPU_FETCH_QUEUE_STATS_EN
    chk("bubble_cnt", q2s_bubble_cnt, (mbub  > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mbub);
    chk("full_cnt",   q2s_full_cnt,   (mfull > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mfull);
`endif
  endtask

  // drive one cycle of inputs, advance the reference across the edge, compare everything
  task automatic cyc(input logic rn, input logic v, input logic [31:0] inst,
                     input logic [PC_W-1:0] pc, input logic adv, input logic li,
                     input logic fl);
    int sz;
    bit push;
    bit pop;
    rst_n        = rn;
    f2q_valid    = v;
    f2q_inst     = inst;
    f2q_pc       = pc;
    d2q_advance  = adv;
    d2q_long_imm = li;
    flush        = fl;
    sz   = mq.size();
    push = v && (sz < DEPTH);
    pop  = adv && (sz > 0);
    @(posedge clk);
    #1;
    if (!rn) begin
      mbub  = 0;
      mfull = 0;
    end else begin
      if (sz == 0 && !fl) mbub++;
      if (sz == DEPTH) mfull++;
    end
    if (!rn || fl) begin
      mq.delete();
      mprev = 1'b0;
    end else begin
      if (pop) begin
        mprev = li && !mprev;
        void'(mq.pop_front());
      end
      if (push) mq.push_back({pc, inst});
    end
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] inst, input logic [PC_W-1:0] pc);
    cyc(1'b1, 1'b1, inst, pc, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    mprev = 1'b0;
    mbub  = 0;
    mfull = 0;

    // reset state
    cyc(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 30'h3, 1'b0, 1'b0, 1'b0);
    chk("rst_ready",      q2f_ready, 1'b1);
    chk("rst_inst_valid", q2d_inst_valid, 1'b0);
    chk("rst_inst_zero",  q2d_inst, 32'h0);

    // fill: A, B, C then D
    push(32'hA000_000A, 30'h100);
    push(32'hB000_000B, 30'h101);
    push(32'hC000_000C, 30'h102);
    chk("abc_inst",  q2d_inst, 32'hA000_000A);
    chk("abc_next",  q2d_nextinst, 32'hB000_000B);
    chk("abc_nv",    q2d_next_valid, 1'b1);
    chk("abc_ready", q2f_ready, 1'b1);
    push(32'hD000_000D, 30'h103);
    chk("full_ready", q2f_ready, 1'b0);

    // full: push and advance together, push refused
    cyc(1'b1, 1'b1, 32'hE000_000E, 30'h104, 1'b1, 1'b0, 1'b0);
    chk("full_pop_ready", q2f_ready, 1'b1);
    chk("full_pop_head",  q2d_inst, 32'hB000_000B);
    chk("full_pop_pc",    q2d_pc, 30'h101);

    // long immediate sequence
    cyc(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
    push(32'hCAFE_0000, 30'h200);
    push(32'h1234_5678, 30'h201);
    push(32'h0BAD_0001, 30'h202);
    cyc(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b1, 1'b0);
    chk("limm_payload", q2d_inst, 32'h1234_5678);
    chk("limm_prev1",   q2d_prev_long_imm, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b1, 1'b0);
    chk("limm_prev0",   q2d_prev_long_imm, 1'b0);
    chk("limm_after",   q2d_inst, 32'h0BAD_0001);

    // flush at count 3 with a push offered
    push(32'h5100_0001, 30'h300);
    push(32'h5100_0002, 30'h301);
    cyc(1'b1, 1'b1, 32'h5EE0_0000, 30'h302, 1'b0, 1'b0, 1'b1);
    chk("flush_iv",    q2d_inst_valid, 1'b0);
    chk("flush_nv",    q2d_next_valid, 1'b0);
    chk("flush_prev",  q2d_prev_long_imm, 1'b0);
    idle();
    chk("flush_drop",  q2d_inst_valid, 1'b0);

    // ten push/pop pairs across pointer wrap
    push(32'h7700_0000, 30'h400);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b1, 32'h7700_0000 + 32'(i), 30'h400 + 30'(i), 1'b1, 1'b0, 1'b0);
      chk("wrap_inst", q2d_inst, 32'h7700_0000 + 32'(i));
      chk("wrap_pc",   q2d_pc, 30'h400 + 30'(i));
    end
    cyc(1'b1, 1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);

    // randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      int sz;
      logic v, adv, li, fl;
      sz  = mq.size();
      v   = ($urandom_range(3) != 0);
      adv = (sz > 0) && ($urandom_range(2) != 0);
      li  = (sz > 1) && ($urandom_range(3) == 0);
      fl  = ($urandom_range(31) == 0);
      w   = $urandom;
      cyc(1'b1, v, w, PC_W'($urandom), adv, li, fl);
    end

    // reset mid-stream, then an empty idle stretch
    push(32'h9900_0001, 30'h500);
    push(32'h9900_0002, 30'h501);
    cyc(1'b0, 1'b1, 32'h9900_0003, 30'h502, 1'b1, 1'b0, 1'b0);
    chk("mrst_ready", q2f_ready, 1'b1);
    chk("mrst_iv",    q2d_inst_valid, 1'b0);
    chk("mrst_nv",    q2d_next_valid, 1'b0);
    chk("mrst_prev",  q2d_prev_long_imm, 1'b0);
    chk("mrst_inst",  q2d_inst, 32'h0);
    chk("mrst_pc",    q2d_pc, 30'h0);
    for (int i = 0; i < 5; i++) idle();
`ifdef MCPU_FETCH_QUEUE_STATS_EN
    chk("bubble5", q2s_bubble_cnt, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
